fpu_sign_stage: RTL and testbench

FPU_SIGN_STAGE -- requirements
Module: fpu_sign_stage

---
 rtl/fpu_sign_stage.sv | 96 +++++++++
 tb/tb_fpu_sign_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_sign_stage.sv
// Two-entry sign-injection pipeline (fsgnj/fsgnjn/fsgnjx) with valid/ready on both sides.
// Stage A registers the request; stage B registers the result so out_* are glitch-free.
module fpu_sign_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_tag,
  input  logic [31:0] in_x1,
  input  logic [31:0] in_x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic [4:0]  out_tag,
  output logic        out_illegal,
  output logic [1:0]  count
);

  logic        a_valid;
  logic [1:0]  a_op;
  logic [4:0]  a_tag;
  logic [31:0] a_x1;
  logic [31:0] a_x2;

  logic        b_valid;
  logic [31:0] b_y;
  logic [4:0]  b_tag;
  logic        b_ill;

  logic        b_adv;
  logic        a_move;
  logic        in_fire;
  logic [31:0] res_y;
  logic        res_ill;

  assign b_adv   = !b_valid || out_ready;
  assign a_move  = a_valid && b_adv;
  assign in_ready = !rst && !flush && (!a_valid || a_move);
  assign in_fire = in_valid && in_ready;

  assign out_valid   = b_valid && !flush && !rst;
  assign out_y       = b_y;
  assign out_tag     = b_tag;
  assign out_illegal = b_ill;
  assign count       = {1'b0, a_valid} + {1'b0, b_valid};

  // Only the sign bit is touched; the other 31 bits pass through, so NaN payloads survive.
  always_comb begin
    res_y   = a_x1;
    res_ill = 1'b0;
    case (a_op)
      2'b00:   res_y = {a_x2[31], a_x1[30:0]};
      2'b01:   res_y = {~a_x2[31], a_x1[30:0]};
      2'b10:   res_y = {a_x1[31] ^ a_x2[31], a_x1[30:0]};
      default: res_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_op    <= '0;
      a_tag   <= '0;
      a_x1    <= '0;
      a_x2    <= '0;
      b_valid <= 1'b0;
      b_y     <= '0;
      b_tag   <= '0;
      b_ill   <= 1'b0;
    end else if (flush) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      if (b_adv) begin
        b_valid <= a_valid;
        if (a_valid) begin
          b_y   <= res_y;
          b_tag <= a_tag;
          b_ill <= res_ill;
        end
      end
      if (in_fire) begin
        a_valid <= 1'b1;
        a_op    <= in_op;
        a_tag   <= in_tag;
        a_x1    <= in_x1;
        a_x2    <= in_x2;
      end else if (a_move) begin
        a_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_sign_stage.sv
// Randomized bench for fpu_sign_stage: a queue of in-flight results models occupancy,
// ordering and handshakes; directed sequences cover the worked examples.
module tb_fpu_sign_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [1:0]  in_op, count;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] in_x1, in_x2, out_y;

  fpu_sign_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .in_x1(in_x1), .in_x2(in_x2),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        ill;
    bit          done;
  } item_t;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    armed   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sign injection described arithmetically: magnitude of x1, sign chosen by the op.
  function automatic item_t ref_item(input logic [1:0] op, input logic [4:0] tag,
                                     input logic [31:0] x1, input logic [31:0] x2);
    item_t it;
    logic [31:0] mag;
    logic s1, s2, s;
    mag = x1 & 32'h7FFF_FFFF;
    s1  = (x1 >= 32'h8000_0000);
    s2  = (x2 >= 32'h8000_0000);
    s   = 1'b0;
    if (op == 2'd0) s = s2;
    else if (op == 2'd1) s = !s2;
    else if (op == 2'd2) s = (s1 != s2);
    it.y    = (op == 2'd3) ? x1 : (s ? mag + 32'h8000_0000 : mag);
    it.tag  = tag;
    it.ill  = (op == 2'd3);
    it.done = 0;
    return it;
  endfunction

  task automatic step(input bit r, input bit f, input bit iv, input logic [1:0] op,
                      input logic [4:0] tag, input logic [31:0] x1, input logic [31:0] x2,
                      input bit ordy);
    bit e_ready, e_ovalid, fire_in, fire_out;
    rst = r; flush = f; in_valid = iv; in_op = op; in_tag = tag;
    in_x1 = x1; in_x2 = x2; out_ready = ordy;
    #1;
    e_ready  = !r && !f && (q.size() < 2 || ordy);
    e_ovalid = !r && !f && q.size() > 0 && q[0].done;
    if (armed) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_ovalid});
      chk("count", {30'b0, count}, q.size());
      if (e_ovalid) begin
        chk("out_y", out_y, q[0].y);
        chk("out_tag", {27'b0, out_tag}, {27'b0, q[0].tag});
        chk("out_illegal", {31'b0, out_illegal}, {31'b0, q[0].ill});
      end
    end
    fire_in  = iv && e_ready;
    fire_out = e_ovalid && ordy;
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      if (fire_out) void'(q.pop_front());
      if (q.size() > 0 && !q[0].done) q[0].done = 1;
      if (fire_in) q.push_back(ref_item(op, tag, x1, x2));
    end
    if (r) armed = 1;
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, ordy);
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] sp[8];
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
           32'h7FC0_0001, 32'hFFBF_FFFF, 32'h0000_0001, 32'h807F_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_op = 0; in_tag = 0;
    in_x1 = 0; in_x2 = 0; out_ready = 0;
    #2;
    step(1, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 1);
    step(1, 0, 1, 2'd1, 5'd7, 32'h1, 32'h1, 1);
    chk("rst_out_y", out_y, 32'h0);
    chk("rst_out_tag", {27'b0, out_tag}, 32'h0);
    chk("rst_out_ill", {31'b0, out_illegal}, 32'h0);

    // fsgnjn: latency of two edges from the offer
    step(0, 0, 1, 2'd1, 5'd3, 32'h3F80_0000, 32'h4000_0000, 1);
    idle(1);
    chk("lat_valid", {31'b0, out_valid}, 32'h1);
    chk("lat_y", out_y, 32'hBF80_0000);
    chk("lat_tag", {27'b0, out_tag}, 32'h3);
    idle(1);

    step(0, 0, 1, 2'd2, 5'd4, 32'hC049_0FDB, 32'h8000_0000, 1);
    step(0, 0, 1, 2'd0, 5'd5, 32'h0000_0000, 32'h8000_0000, 1);
    chk("fsgnjx_y", out_y, 32'h4049_0FDB);
    step(0, 0, 1, 2'd1, 5'd6, 32'h0000_0000, 32'h8000_0000, 1);
    chk("fsgnj_negzero", out_y, 32'h8000_0000);
    step(0, 0, 1, 2'd3, 5'd9, 32'h7FC0_0001, 32'h0, 1);
    chk("fsgnjn_zero", out_y, 32'h0000_0000);
    idle(1);
    chk("illegal_y", out_y, 32'h7FC0_0001);
    chk("illegal_flag", {31'b0, out_illegal}, 32'h1);
    idle(1);

    // back-pressure: two accepted, third stalls until the output drains
    step(0, 0, 1, 2'd0, 5'd1, 32'h1111_1111, 32'h0, 0);
    step(0, 0, 1, 2'd0, 5'd2, 32'h2222_2222, 32'h0, 0);
    step(0, 0, 1, 2'd0, 5'd3, 32'h3333_3333, 32'h0, 0);
    chk("bp_count", {30'b0, count}, 32'd2);
    chk("bp_ready", {31'b0, in_ready}, 32'h0);
    step(0, 0, 1, 2'd0, 5'd3, 32'h3333_3333, 32'h0, 0);
    chk("bp_hold_tag", {27'b0, out_tag}, 32'd1);
    step(0, 0, 1, 2'd0, 5'd3, 32'h3333_3333, 32'h0, 1);
    chk("bp_tag2", {27'b0, out_tag}, 32'd2);
    idle(1);
    chk("bp_tag3", {27'b0, out_tag}, 32'd3);
    idle(1);

    // flush with two held entries and an offer
    step(0, 0, 1, 2'd0, 5'd10, 32'hA, 32'h0, 0);
    step(0, 0, 1, 2'd0, 5'd11, 32'hB, 32'h0, 0);
    step(0, 1, 1, 2'd0, 5'd12, 32'hC, 32'h0, 1);
    chk("flush_count", {30'b0, count}, 32'd0);
    chk("flush_ovalid", {31'b0, out_valid}, 32'h0);
    idle(1);
    idle(1);

    // reset with two held entries
    step(0, 0, 1, 2'd0, 5'd13, 32'hD, 32'h0, 0);
    step(0, 0, 1, 2'd0, 5'd14, 32'hE, 32'h0, 0);
    step(1, 0, 1, 2'd0, 5'd15, 32'hF, 32'h0, 1);
    chk("rst_count", {30'b0, count}, 32'd0);
    idle(1);
    idle(1);
    chk("rst_no_out", {31'b0, out_valid}, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), pick_val(), pick_val(),
           $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
